// File: rtl/bnn_weight_streamer.sv
// -----------------------------------------------------------------------------
// bnn_weight_streamer
//
// Host-side transmitter for the BNN nibble-serial weight-load interface.
// A bank of NUM_NEURONS weight bytes is written by byte address while the
// streamer is idle. On start it replays the bank as 2*NUM_NEURONS nibbles,
// low nibble first, each qualified by load_en_out. The sink can stall the
// stream between any two nibbles with hold_in.
//
// Optional feature macro: BNN_STREAM_XSUM_EN
//   defined   -> xsum holds the XOR of all bytes sent in the last stream
//   undefined -> xsum is tied to 0 and no checksum logic is built
//
// Ports:
//   clk          in   clock, all state changes on its rising edge
//   reset        in   asynchronous active-high reset (clears the bank too)
//   wr_en        in   bank write strobe (honoured only in IDLE/DONE)
//   wr_addr      in   [AW-1:0] bank write address
//   wr_data      in   [7:0] weight byte to write
//   start        in   request one full stream (level-sampled)
//   hold_in      in   stall request from the sink
//   nib_out      out  [3:0] nibble presented to the sink (0 when not busy)
//   load_en_out  out  nibble-valid strobe
//   busy         out  stream in progress
//   done         out  one-cycle pulse after the last nibble
//   xsum         out  [7:0] stream checksum
// -----------------------------------------------------------------------------
module bnn_weight_streamer #(
    parameter int NUM_NEURONS = 8,
    parameter int AW          = $clog2(NUM_NEURONS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          start,
    input  logic          hold_in,
    output logic [3:0]    nib_out,
    output logic          load_en_out,
    output logic          busy,
    output logic          done,
    output logic [7:0]    xsum
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_NEURONS - 1);

    state_t        state_reg;
    logic [AW-1:0] idx_reg;
    logic          busy_reg;
    logic          done_reg;
    logic [7:0]    bank_reg [NUM_NEURONS];
    logic [7:0]    cur_byte;
    logic          wr_ok;
    logic          stream_start;

    // Writes are only accepted outside a stream, so the stream always
    // matches the bank contents at the moment start was sampled.
    assign wr_ok        = wr_en && (state_reg == S_IDLE || state_reg == S_DONE);
    assign stream_start = start && (state_reg == S_IDLE || state_reg == S_DONE);

    // Live read of the byte currently being sent.
    assign cur_byte = bank_reg[idx_reg];

    // -------------------------------------------------------------------------
    // Weight bank: one byte register per neuron, cleared by reset.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_NEURONS; gi++) begin : g_bank
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    bank_reg[gi] <= 8'h00;
                end else if (wr_ok && wr_addr == AW'(gi)) begin
                    bank_reg[gi] <= wr_data;
                end
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Stream FSM. busy/done are registered alongside the state so they
    // always equal "state is LO/HI" and "state is DONE".
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
            idx_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        state_reg <= S_LO;
                        idx_reg   <= '0;
                        busy_reg  <= 1'b1;
                    end
                end
                S_LO: begin
                    if (!hold_in) begin
                        state_reg <= S_HI;
                    end
                end
                S_HI: begin
                    if (!hold_in) begin
                        if (idx_reg == LAST_IDX) begin
                            state_reg <= S_DONE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= S_LO;
                            idx_reg   <= idx_reg + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    done_reg <= 1'b0;
                    idx_reg  <= '0;
                    if (start) begin
                        state_reg <= S_LO;
                        busy_reg  <= 1'b1;
                    end else begin
                        state_reg <= S_IDLE;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Nibble mux: held naturally during a stall since state/idx do not move.
    always_comb begin
        nib_out = 4'h0;
        if (state_reg == S_LO) begin
            nib_out = cur_byte[3:0];
        end else if (state_reg == S_HI) begin
            nib_out = cur_byte[7:4];
        end
    end

    // The stall request gates the strobe in the same cycle.
    assign load_en_out = busy_reg & ~hold_in;
    assign busy        = busy_reg;
    assign done        = done_reg;

`ifdef BNN_STREAM_XSUM_EN
    logic [7:0] xsum_reg;

    // Cleared when a stream begins, then folds in each byte as its high
    // nibble (the second half of the frame) is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xsum_reg <= 8'h00;
        end else if (stream_start) begin
            xsum_reg <= 8'h00;
        end else if (state_reg == S_HI && !hold_in) begin
            xsum_reg <= xsum_reg ^ cur_byte;
        end
    end

    assign xsum = xsum_reg;
`else
    assign xsum = 8'h00;

    logic unused_sig;
    assign unused_sig = stream_start;
`endif

endmodule

// File: tb/tb_bnn_weight_streamer.sv
// -----------------------------------------------------------------------------
// Directed testbench for bnn_weight_streamer (NUM_NEURONS = 8).
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge. Cycle numbering: cycle 1 is the cycle after the edge that
// samples start.
// -----------------------------------------------------------------------------
module tb_bnn_weight_streamer;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       start;
    logic       hold_in;
    logic [3:0] nib_out;
    logic       load_en_out;
    logic       busy;
    logic       done;
    logic [7:0] xsum;

    bnn_weight_streamer #(.NUM_NEURONS(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .start       (start),
        .hold_in     (hold_in),
        .nib_out     (nib_out),
        .load_en_out (load_en_out),
        .busy        (busy),
        .done        (done),
        .xsum        (xsum)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Bench's own view of what the bank should contain.
    logic [7:0] model [8];

    // Per-cycle captures of the most recent run.
    logic       le_a   [64];
    logic [3:0] nib_a  [64];
    logic       busy_a [64];
    logic       done_a [64];
    logic [7:0] xsum_a [64];

    typedef struct {
        logic       hold;
        logic       le;
        logic [3:0] nib;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t tbl [20];

`ifdef BNN_STREAM_XSUM_EN
    localparam logic [7:0] XSUM_ONEHOT = 8'hFF;
`else
    localparam logic [7:0] XSUM_ONEHOT = 8'h00;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input int a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a[2:0];
        wr_data = d;
        tick();
        wr_en   = 1'b0;
        model[a] = d;
        $display("write bank[%0d] = %02h", a, d);
    endtask

    // Launches a stream and captures n cycles of outputs.
    // restart_cyc: cycle in which start is pulsed again (-1 = none)
    // hold_start : keep start high for the whole capture
    // wr_cyc     : cycle in which a write is issued (0 = same edge as start)
    // rst_cyc    : cycle in which reset is asserted for one cycle
    task automatic run(input int n, input logic [63:0] hold_mask, input int restart_cyc,
                       input bit hold_start, input int wr_cyc, input int wr_a,
                       input logic [7:0] wr_d, input int rst_cyc);
        start   = 1'b1;
        wr_en   = (wr_cyc == 0);
        wr_addr = wr_a[2:0];
        wr_data = wr_d;
        tick();
        wr_en = 1'b0;
        for (int c = 1; c <= n; c++) begin
            hold_in = hold_mask[c];
            start   = (c == restart_cyc) ? 1'b1 : hold_start;
            wr_en   = (c == wr_cyc);
            if (c == rst_cyc) reset = 1'b1;
            else if (c == rst_cyc + 1) reset = 1'b0;
            @(negedge clk);
            le_a[c]   = load_en_out;
            nib_a[c]  = nib_out;
            busy_a[c] = busy;
            done_a[c] = done;
            xsum_a[c] = xsum;
            tick();
        end
        start   = 1'b0;
        hold_in = 1'b0;
        wr_en   = 1'b0;
        reset   = 1'b0;
    endtask

    function automatic logic [3:0] exp_nib(input int k);
        logic [7:0] b;
        b = model[(k - 1) / 2];
        return (k % 2 == 1) ? b[3:0] : b[7:4];
    endfunction

    // Compares the strobed nibbles of the last capture against the model
    // bank, plus strobe count, first done cycle and number of done pulses.
    task automatic check_stream(input string name, input int n, input int exp_done, input int exp_ndone);
        int k;
        int first_done;
        int ndone;
        k = 0;
        first_done = -1;
        ndone = 0;
        for (int c = 1; c <= n; c++) begin
            if (le_a[c]) begin
                k++;
                if (k <= 16) check($sformatf("%s_nib%0d", name, k), {28'h0, nib_a[c]}, {28'h0, exp_nib(k)});
            end
            if (done_a[c]) begin
                ndone++;
                if (first_done < 0) first_done = c;
            end
        end
        check($sformatf("%s_strobes", name), k, 16);
        check($sformatf("%s_done_cycle", name), first_done, exp_done);
        check($sformatf("%s_done_count", name), ndone, exp_ndone);
        $display("stream %s: %0d strobes, done in cycle %0d, xsum %02h", name, k, first_done,
                 (first_done > 0) ? xsum_a[first_done] : 8'h00);
    endtask

    initial begin
        logic [63:0] mask;

        tbl[0]  = '{1'b0, 1'b1, 4'h0, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 4'hF, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 4'hF, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 4'hF, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 4'h0, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 4'h0, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 4'hC, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 4'h3, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 4'h3, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 4'hC, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 4'h0, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 4'hF, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 4'hF, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 4'h0, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 4'hC, 1'b1, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 4'h3, 1'b1, 1'b0};
        tbl[16] = '{1'b0, 1'b1, 4'h3, 1'b1, 1'b0};
        tbl[17] = '{1'b0, 1'b1, 4'hC, 1'b1, 1'b0};
        tbl[18] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1};
        tbl[19] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0};

        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_addr = 3'd0;
        wr_data = 8'h00;
        start   = 1'b0;
        hold_in = 1'b0;
        for (int i = 0; i < 8; i++) model[i] = 8'h00;

        // Reset state
        tick();
        tick();
        @(negedge clk);
        check("rst_nib", {28'h0, nib_out}, 32'h0);
        check("rst_load_en", {31'h0, load_en_out}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_xsum", {24'h0, xsum}, 32'h0);
        tick();
        reset = 1'b0;
        tick();

        // Plain stream of the alternating pattern; its checksum cancels to 00
        write_byte(0, 8'hF0); write_byte(1, 8'h0F); write_byte(2, 8'h3C); write_byte(3, 8'hC3);
        write_byte(4, 8'hF0); write_byte(5, 8'h0F); write_byte(6, 8'h3C); write_byte(7, 8'hC3);
        run(20, 64'h0, -1, 1'b0, -1, 0, 8'h00, -1);
        check_stream("plain", 20, 17, 1);
        check("plain_busy_c1", {31'h0, busy_a[1]}, 32'h1);
        check("plain_busy_c16", {31'h0, busy_a[16]}, 32'h1);
        check("plain_busy_c17", {31'h0, busy_a[17]}, 32'h0);
        check("plain_nib_c17", {28'h0, nib_a[17]}, 32'h0);
        check("plain_xsum", {24'h0, xsum_a[17]}, 32'h0);

        // Stalls in cycles 2 and 5, checked cycle by cycle from the table
        mask = '0;
        for (int i = 0; i < 20; i++) mask[i + 1] = tbl[i].hold;
        run(22, mask, -1, 1'b0, -1, 0, 8'h00, -1);
        for (int i = 0; i < 20; i++) begin
            check($sformatf("stall_c%0d", i + 1),
                  {25'h0, le_a[i + 1], nib_a[i + 1], busy_a[i + 1], done_a[i + 1]},
                  {25'h0, tbl[i].le, tbl[i].nib, tbl[i].busy, tbl[i].done});
        end
        check_stream("stall", 22, 19, 1);

        // Write during a stream is dropped, both in that stream and the next
        run(20, 64'h0, -1, 1'b0, 6, 2, 8'hAA, -1);
        check_stream("midwr", 20, 17, 1);
        run(20, 64'h0, -1, 1'b0, -1, 0, 8'h00, -1);
        check_stream("after_midwr", 20, 17, 1);

        // Write on the same edge as start from IDLE is carried by the stream
        model[2] = 8'hAA;
        run(20, 64'h0, -1, 1'b0, 0, 2, 8'hAA, -1);
        check_stream("samewr", 20, 17, 1);
        check("samewr_pos5", {28'h0, nib_a[5]}, 32'hA);
        check("samewr_pos6", {28'h0, nib_a[6]}, 32'hA);
        write_byte(2, 8'h3C);

        // start re-pulsed mid-stream is ignored
        run(24, 64'h0, 8, 1'b0, -1, 0, 8'h00, -1);
        check_stream("restart", 24, 17, 1);

        // start held through DONE: back-to-back streams
        run(20, 64'h0, -1, 1'b1, -1, 0, 8'h00, -1);
        check("b2b_done_c17", {31'h0, done_a[17]}, 32'h1);
        check("b2b_busy_c17", {31'h0, busy_a[17]}, 32'h0);
        check("b2b_lo_c18", {30'h0, le_a[18], busy_a[18]}, 32'h3);
        check("b2b_nib_c18", {28'h0, nib_a[18]}, {28'h0, model[0][3:0]});
        check("b2b_nib_c19", {28'h0, nib_a[19]}, {28'h0, model[0][7:4]});
        for (int i = 0; i < 30; i++) tick();

        // Reset in cycle 7 aborts the stream and clears the bank
        run(12, 64'h0, -1, 1'b0, -1, 0, 8'h00, 7);
        check("rstmid_c6_busy", {31'h0, busy_a[6]}, 32'h1);
        check("rstmid_c7", {25'h0, le_a[7], nib_a[7], busy_a[7], done_a[7]}, 32'h0);
        for (int i = 0; i < 8; i++) model[i] = 8'h00;
        run(20, 64'h0, -1, 1'b0, -1, 0, 8'h00, -1);
        check_stream("zeros", 20, 17, 1);

        // One-hot bank: checksum is FF with the feature on, 00 with it off
        write_byte(0, 8'h01); write_byte(1, 8'h02); write_byte(2, 8'h04); write_byte(3, 8'h08);
        write_byte(4, 8'h10); write_byte(5, 8'h20); write_byte(6, 8'h40); write_byte(7, 8'h80);
        run(20, 64'h0, -1, 1'b0, -1, 0, 8'h00, -1);
        check_stream("onehot", 20, 17, 1);
        check("onehot_xsum_done", {24'h0, xsum_a[17]}, {24'h0, XSUM_ONEHOT});
        check("onehot_xsum_idle", {24'h0, xsum_a[20]}, {24'h0, XSUM_ONEHOT});

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
